// File: rtl/vend_pkg.sv
// Shared constants for the vending-machine input conditioning path.
// Default debounce window is 20 ms at 50 MHz; the short value keeps simulations fast.
package vend_pkg;

  localparam int unsigned CNT_MAX_DEFAULT = 1_000_000;
  localparam int unsigned CNT_MAX_SIM     = 4;

endpackage

// File: rtl/debounce_ch.sv
// One input channel: 2-flop synchronizer, stability counter, debounced level
// and a registered one-cycle flag on each debounced 0->1 transition.
module debounce_ch
  import vend_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_rise
);

  localparam int unsigned CntW = $clog2(CNT_MAX);
  localparam logic [CntW-1:0] CntLast = CntW'(CNT_MAX - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic            r_stable_dly;
  logic            r_rise;
  logic [CntW-1:0] r_cnt;

  logic w_differ;
  logic w_done;

  assign w_differ = (r_sync2 != r_stable);
  // Input has disagreed with the debounced level for CNT_MAX consecutive cycles.
  assign w_done   = w_differ && (r_cnt == CntLast);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_stable     <= 1'b0;
      r_stable_dly <= 1'b0;
      r_rise       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_sync1      <= i_key;
      r_sync2      <= r_sync1;
      if (!w_differ || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_stable <= r_sync2;
      end
      r_stable_dly <= r_stable;
      r_rise       <= r_stable & ~r_stable_dly;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/vend_input_cond.sv
// Debounces the coin and refund contacts and registers the resulting event pulses,
// giving refund priority when both channels fire in the same cycle.
module vend_input_cond
  import vend_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_coin,
  input  logic key_refund,
  output logic coin,
  output logic refund_request,
  output logic conflict
);

  logic w_coin_rise;
  logic w_refund_rise;
  logic r_coin;
  logic r_refund;
  logic r_conflict;

  debounce_ch #(
    .CNT_MAX(CNT_MAX)
  ) u_coin (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .i_key (key_coin),
    .o_rise(w_coin_rise)
  );

  debounce_ch #(
    .CNT_MAX(CNT_MAX)
  ) u_refund (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .i_key (key_refund),
    .o_rise(w_refund_rise)
  );

  // A coin arriving together with a refund is dropped; the refund wins.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_coin     <= 1'b0;
      r_refund   <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_coin     <= w_coin_rise & ~w_refund_rise;
      r_refund   <= w_refund_rise;
      r_conflict <= w_coin_rise & w_refund_rise;
    end
  end

  assign coin           = r_coin;
  assign refund_request = r_refund;
  assign conflict       = r_conflict;

endmodule

// File: doc/vend_input_cond.md
VEND_INPUT_COND -- requirements
Module: vend_input_cond

Interface
REQ-001 Parameter CNT_MAX, default 1_000_000, sets debounce stability window in sys_clk cycles (20 ms at 50 MHz); CNT_MAX >= 2.
REQ-002 sys_clk  input  1  single system clock; all logic on rising edge.
REQ-003 sys_rst  input  1  reset, synchronous, active-high.
REQ-004 key_coin  input  1  raw asynchronous coin-slot contact, 1 = coin present, may bounce.
REQ-005 key_refund  input  1  raw asynchronous refund pushbutton, 1 = pressed, may bounce.
REQ-006 coin  output  1  one-cycle pulse per debounced coin insertion; drives the vending FSM coin input.
REQ-007 refund_request  output  1  one-cycle pulse per debounced refund press; drives the vending FSM refund_request input.
REQ-008 conflict  output  1  one-cycle pulse when a coin event is discarded due to a simultaneous refund event.

Function
REQ-009 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each channel SHALL hold a debounced level "stable" and a counter of width $clog2(CNT_MAX).
REQ-011 Counter SHALL clear in any cycle where the synchronized input equals stable.
REQ-012 Counter SHALL increment while the synchronized input differs from stable.
REQ-013 When counter == CNT_MAX-1 and inputs still differ, stable SHALL take the synchronized value and the counter SHALL clear.
REQ-014 Any glitch or bounce shorter than CNT_MAX consecutive cycles SHALL leave stable unchanged and produce no pulse.
REQ-015 A stable 0->1 transition SHALL produce a registered rise flag, high exactly one cycle.
REQ-016 A stable 1->0 transition (release) SHALL produce no output.
REQ-017 Latency: raw input held high from sampling edge N SHALL give a pulse high during the cycle after edge N+CNT_MAX+3.
REQ-018 An input held high indefinitely SHALL produce exactly one pulse; a new pulse requires a debounced release then press.
REQ-019 Coin rise alone SHALL give coin=1 for one cycle; refund rise alone SHALL give refund_request=1 for one cycle.
REQ-020 Coin and refund rises in the same cycle SHALL give refund_request=1, coin=0, conflict=1 for that one cycle.
REQ-021 coin and refund_request SHALL never be high in the same cycle.
REQ-022 All outputs SHALL be driven directly from flops; no combinational path from inputs to outputs.

Reset
REQ-023 While sys_rst=1 at a clock edge: synchronizers, stable, counters and all outputs SHALL go to 0.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; no pulse is owed afterwards.
REQ-025 An input already high when reset releases SHALL be treated as a new press: one pulse after CNT_MAX+3 cycles.

Structure
REQ-026 Default CNT_MAX and the simulation override value (4) SHALL live in shared package vend_pkg.
REQ-027 Per-channel synchronizer, counter, stable level and rise flag SHALL be sub-module debounce_ch, instantiated twice.
REQ-028 Top level SHALL contain only the two instances and the priority/conflict output register.

Verification (CNT_MAX=4)
REQ-029 key_coin 0->1 held 20 cycles -> coin=1 for exactly 1 cycle, 7 cycles after first sampling edge; refund_request=0 and conflict=0 throughout.
REQ-030 key_refund toggled 1,0,1,0 at 1-cycle intervals, then 0 -> no pulse on any output.
REQ-031 key_coin and key_refund rise on the same edge, both held -> refund_request=1 for 1 cycle, coin=0, conflict=1 in the same cycle.
REQ-032 key_coin press 10 cycles, release 10 cycles, press 10 cycles -> exactly two coin pulses; the vending FSM downstream reaches cola=1.
REQ-033 sys_rst pulsed 2 cycles after key_coin rises, key_coin held -> no pulse before reset; one coin pulse 7 cycles after the reset-release edge.
REQ-034 key_coin held high across reset assertion and release -> exactly one coin pulse after release, none during reset.
